// File: rtl/hk_frame_pkg.sv
// Shared types and byte map for the housekeeping frame packer.
// The frame is HEADER(2) + seq + snapshot payload(24) + checksum = 28 bytes.
package hk_frame_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int FRAME_LEN = 28;

    localparam logic [4:0] IDX_HDR_HI = 5'd0;
    localparam logic [4:0] IDX_HDR_LO = 5'd1;
    localparam logic [4:0] IDX_SEQ    = 5'd2;
    localparam logic [4:0] IDX_SEL    = 5'd3;
    localparam logic [4:0] IDX_HERR   = 5'd4;
    localparam logic [4:0] IDX_BERR   = 5'd5;
    localparam logic [4:0] IDX_HCNT0  = 5'd6;
    localparam logic [4:0] IDX_HCNT1  = 5'd10;
    localparam logic [4:0] IDX_BUSY   = 5'd14;
    localparam logic [4:0] IDX_HSTART = 5'd16;
    localparam logic [4:0] IDX_LMATCH = 5'd18;
    localparam logic [4:0] IDX_EFF    = 5'd20;
    localparam logic [4:0] IDX_COIN   = 5'd22;
    localparam logic [4:0] IDX_EXT    = 5'd24;
    localparam logic [4:0] IDX_TDLY   = 5'd26;
    localparam logic [4:0] LAST_IDX   = 5'd27;

    // Frozen copy of the counter block outputs plus the frame's sequence number.
    typedef struct packed {
        logic [7:0]  seq;
        logic [2:0]  hit_monit_sel;
        logic [7:0]  hit_monit_err_cnt;
        logic [7:0]  busy_monit_err_cnt;
        logic [31:0] hit_monit_cnt_0;
        logic [31:0] hit_monit_cnt_1;
        logic [15:0] busy_monit_cnt;
        logic [15:0] hit_start_cnt;
        logic [15:0] logic_match_cnt;
        logic [15:0] eff_trg_cnt;
        logic [15:0] coincid_trg_cnt;
        logic [15:0] ext_trg_cnt;
        logic [7:0]  trg_delay_timer;
    } snap_t;

    // Multi-byte fields go out MSB first.
    function automatic logic [7:0] frame_byte(
        input logic [4:0]  idx,
        input snap_t       s,
        input logic [15:0] hdr,
        input logic [7:0]  chk
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            IDX_HDR_HI:        b = hdr[15:8];
            IDX_HDR_LO:        b = hdr[7:0];
            IDX_SEQ:           b = s.seq;
            IDX_SEL:           b = {5'b0, s.hit_monit_sel};
            IDX_HERR:          b = s.hit_monit_err_cnt;
            IDX_BERR:          b = s.busy_monit_err_cnt;
            IDX_HCNT0:         b = s.hit_monit_cnt_0[31:24];
            IDX_HCNT0 + 5'd1:  b = s.hit_monit_cnt_0[23:16];
            IDX_HCNT0 + 5'd2:  b = s.hit_monit_cnt_0[15:8];
            IDX_HCNT0 + 5'd3:  b = s.hit_monit_cnt_0[7:0];
            IDX_HCNT1:         b = s.hit_monit_cnt_1[31:24];
            IDX_HCNT1 + 5'd1:  b = s.hit_monit_cnt_1[23:16];
            IDX_HCNT1 + 5'd2:  b = s.hit_monit_cnt_1[15:8];
            IDX_HCNT1 + 5'd3:  b = s.hit_monit_cnt_1[7:0];
            IDX_BUSY:          b = s.busy_monit_cnt[15:8];
            IDX_BUSY + 5'd1:   b = s.busy_monit_cnt[7:0];
            IDX_HSTART:        b = s.hit_start_cnt[15:8];
            IDX_HSTART + 5'd1: b = s.hit_start_cnt[7:0];
            IDX_LMATCH:        b = s.logic_match_cnt[15:8];
            IDX_LMATCH + 5'd1: b = s.logic_match_cnt[7:0];
            IDX_EFF:           b = s.eff_trg_cnt[15:8];
            IDX_EFF + 5'd1:    b = s.eff_trg_cnt[7:0];
            IDX_COIN:          b = s.coincid_trg_cnt[15:8];
            IDX_COIN + 5'd1:   b = s.coincid_trg_cnt[7:0];
            IDX_EXT:           b = s.ext_trg_cnt[15:8];
            IDX_EXT + 5'd1:    b = s.ext_trg_cnt[7:0];
            IDX_TDLY:          b = s.trg_delay_timer;
            LAST_IDX:          b = chk;
            default:           b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/hk_cnt_frame_packer.sv
// Snapshots the counter block on update_end_in rising edge, streams a 28-byte housekeeping frame.
// Latency: first byte valid 1 cycle after the request edge; 28 cycles minimum per frame.
// Backpressure: byte_ready_in low holds data/last stable; requests arriving mid-frame are counted as drops.
module hk_cnt_frame_packer
    import hk_frame_pkg::*;
#(
    parameter logic [15:0] HEADER   = 16'hEB90,
    parameter logic [7:0]  CHK_INIT = 8'h00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        update_end_in,
    input  logic [2:0]  hit_monit_sel_in,
    input  logic [7:0]  hit_monit_err_cnt_in,
    input  logic [7:0]  busy_monit_err_cnt_in,
    input  logic [31:0] hit_monit_cnt_0_in,
    input  logic [31:0] hit_monit_cnt_1_in,
    input  logic [15:0] busy_monit_cnt_in,
    input  logic [15:0] hit_start_cnt_in,
    input  logic [15:0] logic_match_cnt_in,
    input  logic [15:0] eff_trg_cnt_in,
    input  logic [15:0] coincid_trg_cnt_in,
    input  logic [15:0] ext_trg_cnt_in,
    input  logic [7:0]  trg_delay_timer_in,
    input  logic        byte_ready_in,
    output logic [7:0]  byte_data_out,
    output logic        byte_valid_out,
    output logic        byte_last_out,
    output logic        frame_busy_out,
    output logic [7:0]  frame_seq_out,
    output logic [7:0]  frame_drop_cnt_out
);

    state_t      state_q;
    state_t      state_d;
    logic        upd_d1;
    logic [4:0]  idx_q;
    snap_t       snap_q;
    logic [7:0]  chk_q;
    logic [7:0]  seq_q;
    logic [7:0]  frame_seq_q;
    logic [7:0]  drop_q;

    logic        req;
    logic        xfer;
    logic        at_last;
    logic [7:0]  cur_byte;

    assign req      = update_end_in & ~upd_d1;
    assign xfer     = (state_q == SEND) & byte_ready_in;
    assign at_last  = (idx_q == LAST_IDX);
    assign cur_byte = frame_byte(idx_q, snap_q, HEADER, chk_q);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            upd_d1  <= 1'b0;
        end else begin
            state_q <= state_d;
            upd_d1  <= update_end_in;
        end
    end

    always_comb begin
        state_d            = state_q;
        byte_valid_out     = 1'b0;
        frame_busy_out     = 1'b0;
        byte_last_out      = 1'b0;
        byte_data_out      = 8'h00;
        frame_seq_out      = frame_seq_q;
        frame_drop_cnt_out = drop_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                byte_valid_out = 1'b1;
                frame_busy_out = 1'b1;
                byte_last_out  = at_last;
                byte_data_out  = cur_byte;
                if (xfer && at_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx_q       <= 5'd0;
            snap_q      <= '0;
            chk_q       <= 8'h00;
            seq_q       <= 8'h00;
            frame_seq_q <= 8'h00;
        end else if (state_q == IDLE) begin
            if (req) begin
                snap_q.seq                <= seq_q;
                snap_q.hit_monit_sel      <= hit_monit_sel_in;
                snap_q.hit_monit_err_cnt  <= hit_monit_err_cnt_in;
                snap_q.busy_monit_err_cnt <= busy_monit_err_cnt_in;
                snap_q.hit_monit_cnt_0    <= hit_monit_cnt_0_in;
                snap_q.hit_monit_cnt_1    <= hit_monit_cnt_1_in;
                snap_q.busy_monit_cnt     <= busy_monit_cnt_in;
                snap_q.hit_start_cnt      <= hit_start_cnt_in;
                snap_q.logic_match_cnt    <= logic_match_cnt_in;
                snap_q.eff_trg_cnt        <= eff_trg_cnt_in;
                snap_q.coincid_trg_cnt    <= coincid_trg_cnt_in;
                snap_q.ext_trg_cnt        <= ext_trg_cnt_in;
                snap_q.trg_delay_timer    <= trg_delay_timer_in;
                idx_q                     <= 5'd0;
                chk_q                     <= CHK_INIT;
                frame_seq_q               <= seq_q;
                seq_q                     <= seq_q + 8'd1;
            end
        end else if (xfer) begin
            // Checksum covers the seq byte through the trigger delay byte only.
            if (idx_q >= IDX_SEQ && idx_q <= IDX_TDLY) begin
                chk_q <= chk_q + cur_byte;
            end
            if (!at_last) begin
                idx_q <= idx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            drop_q <= 8'h00;
        end else if (req && state_q == SEND && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_hk_cnt_frame_packer.sv
// Directed bench for hk_cnt_frame_packer: frame content, stalls, drops, seq wrap, async reset.
module tb_hk_cnt_frame_packer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        update_end_in;
    logic [2:0]  hit_monit_sel_in;
    logic [7:0]  hit_monit_err_cnt_in;
    logic [7:0]  busy_monit_err_cnt_in;
    logic [31:0] hit_monit_cnt_0_in;
    logic [31:0] hit_monit_cnt_1_in;
    logic [15:0] busy_monit_cnt_in;
    logic [15:0] hit_start_cnt_in;
    logic [15:0] logic_match_cnt_in;
    logic [15:0] eff_trg_cnt_in;
    logic [15:0] coincid_trg_cnt_in;
    logic [15:0] ext_trg_cnt_in;
    logic [7:0]  trg_delay_timer_in;
    logic        byte_ready_in;
    logic [7:0]  byte_data_out;
    logic        byte_valid_out;
    logic        byte_last_out;
    logic        frame_busy_out;
    logic [7:0]  frame_seq_out;
    logic [7:0]  frame_drop_cnt_out;

    always #5 clk_in = ~clk_in;

    hk_cnt_frame_packer dut (
        .clk_in                (clk_in),
        .rst_in                (rst_in),
        .update_end_in         (update_end_in),
        .hit_monit_sel_in      (hit_monit_sel_in),
        .hit_monit_err_cnt_in  (hit_monit_err_cnt_in),
        .busy_monit_err_cnt_in (busy_monit_err_cnt_in),
        .hit_monit_cnt_0_in    (hit_monit_cnt_0_in),
        .hit_monit_cnt_1_in    (hit_monit_cnt_1_in),
        .busy_monit_cnt_in     (busy_monit_cnt_in),
        .hit_start_cnt_in      (hit_start_cnt_in),
        .logic_match_cnt_in    (logic_match_cnt_in),
        .eff_trg_cnt_in        (eff_trg_cnt_in),
        .coincid_trg_cnt_in    (coincid_trg_cnt_in),
        .ext_trg_cnt_in        (ext_trg_cnt_in),
        .trg_delay_timer_in    (trg_delay_timer_in),
        .byte_ready_in         (byte_ready_in),
        .byte_data_out         (byte_data_out),
        .byte_valid_out        (byte_valid_out),
        .byte_last_out         (byte_last_out),
        .frame_busy_out        (frame_busy_out),
        .frame_seq_out         (frame_seq_out),
        .frame_drop_cnt_out    (frame_drop_cnt_out)
    );

    int         total = 0;
    int         bad = 0;
    logic [7:0] rx_b [28];
    logic [7:0] exp_b [28];
    int         rx_n;
    int         rx_last_err;
    int         rx_valid_cyc;
    int         rx_stall_err;
    logic [7:0] exp_seq;
    int         seq_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Reference frame built straight from the stimulus values.
    task automatic build_exp(input logic [7:0] sq);
        logic [7:0] sum;
        exp_b[0]  = 8'hEB;
        exp_b[1]  = 8'h90;
        exp_b[2]  = sq;
        exp_b[3]  = {5'b0, hit_monit_sel_in};
        exp_b[4]  = hit_monit_err_cnt_in;
        exp_b[5]  = busy_monit_err_cnt_in;
        for (int i = 0; i < 4; i++) begin
            exp_b[6 + i]  = 8'(hit_monit_cnt_0_in >> (24 - 8 * i));
            exp_b[10 + i] = 8'(hit_monit_cnt_1_in >> (24 - 8 * i));
        end
        exp_b[14] = busy_monit_cnt_in[15:8];  exp_b[15] = busy_monit_cnt_in[7:0];
        exp_b[16] = hit_start_cnt_in[15:8];   exp_b[17] = hit_start_cnt_in[7:0];
        exp_b[18] = logic_match_cnt_in[15:8]; exp_b[19] = logic_match_cnt_in[7:0];
        exp_b[20] = eff_trg_cnt_in[15:8];     exp_b[21] = eff_trg_cnt_in[7:0];
        exp_b[22] = coincid_trg_cnt_in[15:8]; exp_b[23] = coincid_trg_cnt_in[7:0];
        exp_b[24] = ext_trg_cnt_in[15:8];     exp_b[25] = ext_trg_cnt_in[7:0];
        exp_b[26] = trg_delay_timer_in;
        sum = 8'h00;
        for (int i = 2; i <= 26; i++) sum = sum + exp_b[i];
        exp_b[27] = sum;
    endtask

    function automatic int count_mismatch();
        int n = 0;
        for (int i = 0; i < 28; i++) if (rx_b[i] !== exp_b[i]) n++;
        return n;
    endfunction

    // Collects nb accepted bytes; ready driven at negedge, data sampled there too.
    task automatic get_frame(input int nb, input bit rnd);
        logic [7:0] hd;
        logic       hl;
        bit         hold;
        int         cyc;
        rx_n = 0; rx_last_err = 0; rx_valid_cyc = 0; rx_stall_err = 0;
        hold = 1'b0; cyc = 0; hd = 8'h00; hl = 1'b0;
        while (rx_n < nb && cyc < 2000) begin
            @(negedge clk_in);
            cyc++;
            byte_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid_out) begin
                rx_valid_cyc++;
                if (hold && (byte_data_out !== hd || byte_last_out !== hl)) rx_stall_err++;
                if (byte_ready_in) begin
                    rx_b[rx_n] = byte_data_out;
                    if (byte_last_out !== (rx_n == 27)) rx_last_err++;
                    rx_n++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    hd = byte_data_out;
                    hl = byte_last_out;
                end
            end
        end
        if (rx_n != nb) check("rx_timeout", rx_n, nb);
    endtask

    task automatic end_frame();
        @(negedge clk_in);
        byte_ready_in = 1'b0;
    endtask

    task automatic pulse(input bit lat);
        @(negedge clk_in);
        update_end_in = 1'b1;
        @(negedge clk_in);
        update_end_in = 1'b0;
        if (lat) check("first_valid_latency", byte_valid_out, 1'b1);
    endtask

    initial begin
        rst_in = 1'b0;
        update_end_in = 1'b0;
        byte_ready_in = 1'b0;
        hit_monit_sel_in = '0; hit_monit_err_cnt_in = '0; busy_monit_err_cnt_in = '0;
        hit_monit_cnt_0_in = '0; hit_monit_cnt_1_in = '0; busy_monit_cnt_in = '0;
        hit_start_cnt_in = '0; logic_match_cnt_in = '0; eff_trg_cnt_in = '0;
        coincid_trg_cnt_in = '0; ext_trg_cnt_in = '0; trg_delay_timer_in = '0;
        exp_seq = 8'h00;
        repeat (3) @(negedge clk_in);
        check("rst_valid", byte_valid_out, 1'b0);
        check("rst_busy", frame_busy_out, 1'b0);
        check("rst_last", byte_last_out, 1'b0);
        check("rst_data", byte_data_out, 8'h00);
        check("rst_seq", frame_seq_out, 8'h00);
        check("rst_drop", frame_drop_cnt_out, 8'h00);
        rst_in = 1'b1;
        @(negedge clk_in);

        // All-zero counters.
        build_exp(exp_seq);
        pulse(1'b1);
        check("zero_busy", frame_busy_out, 1'b1);
        check("zero_seq_out", frame_seq_out, 8'h00);
        get_frame(28, 1'b0);
        check("zero_bytes", count_mismatch(), 0);
        check("zero_hdr_hi", rx_b[0], 8'hEB);
        check("zero_hdr_lo", rx_b[1], 8'h90);
        check("zero_chk", rx_b[27], 8'h00);
        check("zero_last", rx_last_err, 0);
        check("zero_valid_cyc", rx_valid_cyc, 28);
        end_frame();
        check("zero_valid_end", byte_valid_out, 1'b0);
        check("zero_busy_end", frame_busy_out, 1'b0);
        exp_seq++;

        // Big-endian count, frozen snapshot under input change.
        hit_monit_cnt_0_in = 32'h12345678;
        build_exp(exp_seq);
        pulse(1'b1);
        hit_monit_cnt_0_in = 32'hFFFFFFFF;
        get_frame(28, 1'b0);
        check("h0_bytes", count_mismatch(), 0);
        check("h0_b6", rx_b[6], 8'h12);
        check("h0_b9", rx_b[9], 8'h78);
        check("h0_seq", rx_b[2], 8'h01);
        check("h0_chk", rx_b[27], 8'h15);
        end_frame();
        exp_seq++;

        // Random payload under random backpressure.
        hit_monit_sel_in = 3'd5; hit_monit_err_cnt_in = 8'hA1; busy_monit_err_cnt_in = 8'h3C;
        hit_monit_cnt_0_in = 32'hDEADBEEF; hit_monit_cnt_1_in = 32'h0BADF00D;
        busy_monit_cnt_in = 16'h1234; hit_start_cnt_in = 16'hFFFF; logic_match_cnt_in = 16'h8001;
        eff_trg_cnt_in = 16'h00FF; coincid_trg_cnt_in = 16'h7E7E; ext_trg_cnt_in = 16'hC0DE;
        trg_delay_timer_in = 8'h99;
        build_exp(exp_seq);
        pulse(1'b1);
        get_frame(28, 1'b1);
        check("stall_bytes", count_mismatch(), 0);
        check("stall_stable", rx_stall_err, 0);
        check("stall_last", rx_last_err, 0);
        end_frame();
        exp_seq++;

        // Level held high for 10 us gives one frame.
        build_exp(exp_seq);
        @(negedge clk_in);
        update_end_in = 1'b1;
        repeat (1000) @(negedge clk_in);
        get_frame(28, 1'b0);
        check("hold_bytes", count_mismatch(), 0);
        repeat (5) @(negedge clk_in);
        byte_ready_in = 1'b0;
        check("hold_one_frame", byte_valid_out, 1'b0);
        check("hold_no_drop", frame_drop_cnt_out, 8'h00);
        update_end_in = 1'b0;
        exp_seq++;

        // Requests during a stalled frame are dropped, saturating at 255.
        build_exp(exp_seq);
        pulse(1'b1);
        pulse(1'b0);
        check("drop_one", frame_drop_cnt_out, 8'd1);
        check("drop_no_restart_seq", frame_seq_out, exp_seq);
        check("drop_no_restart_data", byte_data_out, 8'hEB);
        repeat (299) pulse(1'b0);
        check("drop_saturate", frame_drop_cnt_out, 8'hFF);
        get_frame(28, 1'b0);
        check("drop_frame_bytes", count_mismatch(), 0);
        end_frame();
        exp_seq++;

        // 256 frames to cross FF -> 00.
        seq_err = 0;
        for (int f = 0; f < 256; f++) begin
            build_exp(exp_seq);
            pulse(1'b0);
            get_frame(28, 1'b0);
            end_frame();
            if (count_mismatch() != 0) seq_err++;
            if (exp_seq == 8'hFF) check("wrap_ff", rx_b[2], 8'hFF);
            if (exp_seq == 8'h00) check("wrap_00", rx_b[2], 8'h00);
            exp_seq++;
        end
        check("wrap_frames", seq_err, 0);

        // Asynchronous reset at byte index 10.
        pulse(1'b0);
        get_frame(10, 1'b0);
        @(negedge clk_in);
        byte_ready_in = 1'b0;
        #1;
        rst_in = 1'b0;
        #1;
        check("arst_valid", byte_valid_out, 1'b0);
        check("arst_busy", frame_busy_out, 1'b0);
        check("arst_seq", frame_seq_out, 8'h00);
        check("arst_drop", frame_drop_cnt_out, 8'h00);
        @(negedge clk_in);
        rst_in = 1'b1;
        exp_seq = 8'h00;
        build_exp(exp_seq);
        pulse(1'b1);
        get_frame(28, 1'b0);
        check("arst_frame_bytes", count_mismatch(), 0);
        check("arst_frame_seq", rx_b[2], 8'h00);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
